// File: rtl/knn_stream_if.sv
// Query/stream/result bundle for the streaming KNN core.
// The master side issues queries and points; the slave side returns the sorted neighbour list.
interface knn_stream_if #(
  parameter int COORD_W = 16,
  parameter int K       = 6,
  parameter int N_MAX   = 128
);
  localparam int IDX_W  = $clog2(N_MAX);
  localparam int DIST_W = 2*COORD_W + 1;

  logic                    start;
  logic [2*COORD_W-1:0]    test_pt;
  logic [IDX_W:0]          num_pts;
  logic                    pt_valid;
  logic                    pt_ready;
  logic [2*COORD_W-1:0]    pt_data;
  logic                    busy;
  logic                    done;
  logic [K*DIST_W-1:0]     nbr_dist;
  logic [K*IDX_W-1:0]      nbr_idx;
  logic [K-1:0]            nbr_vld;

  modport master (output start, test_pt, num_pts, pt_valid, pt_data,
                  input  pt_ready, busy, done, nbr_dist, nbr_idx, nbr_vld);
  modport slave  (input  start, test_pt, num_pts, pt_valid, pt_data,
                  output pt_ready, busy, done, nbr_dist, nbr_idx, nbr_vld);
endinterface

// File: rtl/knn_stream_core.sv
// Streaming K-nearest-neighbour engine: one point per cycle through a 3-stage
// distance pipeline into a K-deep sorted insertion list.
module knn_stream_core #(
  parameter int COORD_W = 16,
  parameter int K       = 6,
  parameter int N_MAX   = 128
) (
  input  logic        clk,
  input  logic        rst,
  knn_stream_if.slave bus
);
  localparam int IDX_W  = $clog2(N_MAX);
  localparam int DIST_W = 2*COORD_W + 1;
  localparam int CNT_W  = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt, cnt_nxt, n_lat, n_sat;
  logic [1:0]            drain_cnt;
  logic [2*COORD_W-1:0]  tpt;
  logic                  pt_ready_r, busy_r, done_r;
  logic                  accept, clr;

  assign n_sat   = (bus.num_pts > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : bus.num_pts;
  assign accept  = bus.pt_valid & pt_ready_r;
  assign clr     = (state == IDLE) & bus.start;
  assign cnt_nxt = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      n_lat      <= '0;
      drain_cnt  <= '0;
      tpt        <= '0;
      pt_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            tpt       <= bus.test_pt;
            n_lat     <= n_sat;
            cnt       <= '0;
            drain_cnt <= '0;
            busy_r    <= 1'b1;
            if (n_sat == '0) state <= DRAIN;
            else begin
              state      <= LOAD;
              pt_ready_r <= 1'b1;
            end
          end
        end
        LOAD: if (accept) begin
          cnt <= cnt_nxt;
          if (cnt_nxt == n_lat) begin
            state      <= DRAIN;
            pt_ready_r <= 1'b0;
          end
        end
        DRAIN: begin
          // three cycles lets the final accepted point clear S1..S3
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd2) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // distance pipeline: S1 abs diffs, S2 squared distance, S3 list insert
  logic [2:1]             vld_pipe;
  logic [COORD_W-1:0]     px, py, tx, ty, s1_dx, s1_dy;
  logic [IDX_W-1:0]       s1_idx, s2_idx;
  logic [DIST_W-1:0]      s2_d;

  assign px = bus.pt_data[COORD_W-1:0];
  assign py = bus.pt_data[2*COORD_W-1:COORD_W];
  assign tx = tpt[COORD_W-1:0];
  assign ty = tpt[2*COORD_W-1:COORD_W];

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[1], accept};
    s1_dx  <= (px >= tx) ? px - tx : tx - px;
    s1_dy  <= (py >= ty) ? py - ty : ty - py;
    s1_idx <= cnt[IDX_W-1:0];
    s2_d   <= DIST_W'(s1_dx) * DIST_W'(s1_dx) + DIST_W'(s1_dy) * DIST_W'(s1_dy);
    s2_idx <= s1_idx;
  end

  logic [K-1:0][DIST_W-1:0] slot_dist, nxt_dist;
  logic [K-1:0][IDX_W-1:0]  slot_idx, nxt_idx;
  logic [K-1:0]             slot_vld, nxt_vld, better;

  // better[] is monotone over a sorted list, so the first set bit is the insert point
  // and everything behind it shifts down by one; strict < keeps earlier arrivals ahead on ties.
  for (genvar i = 0; i < K; i++) begin : g_slot
    assign better[i] = ~slot_vld[i] | (s2_d < slot_dist[i]);
    if (i == 0) begin : g_head
      assign nxt_dist[i] = better[i] ? s2_d   : slot_dist[i];
      assign nxt_idx[i]  = better[i] ? s2_idx : slot_idx[i];
      assign nxt_vld[i]  = better[i] | slot_vld[i];
    end else begin : g_tail
      assign nxt_dist[i] = better[i-1] ? slot_dist[i-1] : better[i] ? s2_d   : slot_dist[i];
      assign nxt_idx[i]  = better[i-1] ? slot_idx[i-1]  : better[i] ? s2_idx : slot_idx[i];
      assign nxt_vld[i]  = better[i-1] ? slot_vld[i-1]  : (better[i] | slot_vld[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot_dist <= '1;
      slot_idx  <= '1;
      slot_vld  <= '0;
    end else if (vld_pipe[2]) begin
      slot_dist <= nxt_dist;
      slot_idx  <= nxt_idx;
      slot_vld  <= nxt_vld;
    end
  end

  assign bus.pt_ready = pt_ready_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.nbr_dist = slot_dist;
  assign bus.nbr_idx  = slot_idx;
  assign bus.nbr_vld  = slot_vld;
endmodule

// File: tb/tb_knn_stream_core.sv
// Bench for knn_stream_core: fixed vector table, randomized queries against a
// selection-based reference model, and hand sequences for start-glitch and mid-query reset.
module tb_knn_stream_core;
  localparam int CW = 16, K = 6, NM = 128;
  localparam int IW = $clog2(NM);
  localparam int DW = 2*CW + 1;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  knn_stream_if #(.COORD_W(CW), .K(K), .N_MAX(NM)) bus ();
  knn_stream_core #(.COORD_W(CW), .K(K), .N_MAX(NM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  logic [31:0]   pts [256];
  logic [DW-1:0] exp_dist [K];
  logic [IW-1:0] exp_idx  [K];
  logic [K-1:0]  exp_vld;

  typedef struct {
    string                  name;
    logic [31:0]            tp;
    int                     n;
    logic [7:0][31:0]       pv;
    logic [K-1:0][DW-1:0]   edist;
    logic [K-1:0][IW-1:0]   eidx;
    logic [K-1:0]           evld;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: repeatedly pick the nearest unused point, lowest index on ties.
  task automatic model(input logic [31:0] tp, input int n);
    longint d [256];
    bit used [256];
    longint dx, dy;
    for (int j = 0; j < n; j++) begin
      dx = longint'(pts[j][15:0])  - longint'(tp[15:0]);
      dy = longint'(pts[j][31:16]) - longint'(tp[31:16]);
      d[j] = dx*dx + dy*dy;
      used[j] = 1'b0;
    end
    for (int s = 0; s < K; s++) begin
      int best = -1;
      for (int j = 0; j < n; j++)
        if (!used[j] && (best < 0 || d[j] < d[best])) best = j;
      if (best >= 0) begin
        used[best] = 1'b1;
        exp_dist[s] = d[best][DW-1:0];
        exp_idx[s]  = best[IW-1:0];
        exp_vld[s]  = 1'b1;
      end else begin
        exp_dist[s] = '1;
        exp_idx[s]  = '1;
        exp_vld[s]  = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int s = 0; s < K; s++) begin
      chk($sformatf("%s dist[%0d]", tag, s), 64'(bus.nbr_dist[s*DW +: DW]), 64'(exp_dist[s]));
      if (exp_vld[s])
        chk($sformatf("%s idx[%0d]", tag, s), 64'(bus.nbr_idx[s*IW +: IW]), 64'(exp_idx[s]));
    end
    chk({tag, " vld"}, 64'(bus.nbr_vld), 64'(exp_vld));
  endtask

  task automatic do_query(input string tag, input logic [31:0] tp, input int n,
                          input int vprob, input bit glitch);
    int  n_eff = (n > NM) ? NM : n;
    int  k = 0, cyc = 0, last = 0;
    bit  acc, seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.test_pt = tp; bus.num_pts = n[IW:0];
    @(negedge clk);
    bus.start = 1'b0; bus.test_pt = $urandom; bus.num_pts = 8'($urandom_range(255));
    chk({tag, " busy"}, 64'(bus.busy), 64'd1);
    while (cyc < 2000 && !seen) begin
      if (bus.done) seen = 1'b1;
      else begin
        bus.start    = glitch && (cyc == 2);
        bus.pt_valid = ($urandom_range(99) < vprob);
        bus.pt_data  = pts[k];
        acc = bus.pt_ready && bus.pt_valid;
        @(negedge clk);
        cyc++;
        if (acc) begin k++; last = cyc; end
      end
    end
    bus.pt_valid = 1'b0; bus.start = 1'b0;
    chk({tag, " done seen"}, 64'(seen), 64'd1);
    chk({tag, " accepts"}, 64'(k), 64'(n_eff));
    chk({tag, " done latency"}, 64'(cyc), 64'(last + 3));
    check_outputs(tag);
    @(negedge clk);
    chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
    chk({tag, " idle busy"}, 64'(bus.busy), 64'd0);
    check_outputs({tag, " hold"});
  endtask

  initial begin
    bus.start = 1'b0; bus.test_pt = '0; bus.num_pts = '0;
    bus.pt_valid = 1'b0; bus.pt_data = '0;

    // vector table
    vecs[0].name = "T1 line"; vecs[0].tp = 32'h0; vecs[0].n = 8;
    for (int j = 0; j < 8; j++) vecs[0].pv[j] = {16'd0, 16'(7 - j)};
    for (int s = 0; s < K; s++) begin
      vecs[0].edist[s] = DW'(s*s); vecs[0].eidx[s] = IW'(7 - s);
    end
    vecs[0].evld = 6'h3F;

    vecs[1].name = "T2 short"; vecs[1].tp = 32'h0; vecs[1].n = 3; vecs[1].pv = '0;
    vecs[1].pv[0] = {16'd4, 16'd3}; vecs[1].pv[1] = {16'd1, 16'd1}; vecs[1].pv[2] = {16'd2, 16'd0};
    vecs[1].edist = '1; vecs[1].eidx = '1;
    vecs[1].edist[0] = DW'(2);  vecs[1].eidx[0] = IW'(1);
    vecs[1].edist[1] = DW'(4);  vecs[1].eidx[1] = IW'(2);
    vecs[1].edist[2] = DW'(25); vecs[1].eidx[2] = IW'(0);
    vecs[1].evld = 6'b000111;

    vecs[2].name = "T3 ties"; vecs[2].tp = {16'd5, 16'd5}; vecs[2].n = 4; vecs[2].pv = '0;
    vecs[2].edist = '1; vecs[2].eidx = '1;
    for (int j = 0; j < 4; j++) begin
      vecs[2].pv[j] = {16'd5, 16'd5}; vecs[2].edist[j] = '0; vecs[2].eidx[j] = IW'(j);
    end
    vecs[2].evld = 6'b001111;

    vecs[3].name = "T4 extreme"; vecs[3].tp = 32'h0; vecs[3].n = 1; vecs[3].pv = '0;
    vecs[3].pv[0] = 32'hFFFF_FFFF;
    vecs[3].edist = '1; vecs[3].eidx = '1;
    vecs[3].edist[0] = 33'h1_FFFC_0002; vecs[3].eidx[0] = '0;
    vecs[3].evld = 6'b000001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pt_ready", 64'(bus.pt_ready), 64'd0);
    chk("reset busy",     64'(bus.busy),     64'd0);
    chk("reset done",     64'(bus.done),     64'd0);
    chk("reset vld",      64'(bus.nbr_vld),  64'd0);
    chk("reset dist0",    64'(bus.nbr_dist[DW-1:0]), 64'h1_FFFF_FFFF);
    chk("reset idx0",     64'(bus.nbr_idx[IW-1:0]),  64'h7F);
    rst = 1'b0;

    foreach (vecs[v]) begin
      for (int j = 0; j < 8; j++) pts[j] = vecs[v].pv[j];
      for (int s = 0; s < K; s++) begin
        exp_dist[s] = vecs[v].edist[s]; exp_idx[s] = vecs[v].eidx[s];
      end
      exp_vld = vecs[v].evld;
      do_query(vecs[v].name, vecs[v].tp, vecs[v].n, 100, 1'b0);
    end

    // T5: empty query, and start pulsed during LOAD must be ignored
    model(32'h1234_5678, 0);
    do_query("T5 zero", 32'h1234_5678, 0, 60, 1'b0);
    for (int j = 0; j < 20; j++) pts[j] = $urandom;
    model(32'h8000_8000, 20);
    do_query("T5 glitch", 32'h8000_8000, 20, 100, 1'b1);

    // randomized queries, small coordinate range in some to force ties
    for (int q = 0; q < 6; q++) begin
      int n;
      logic [31:0] tp;
      n = (q == 0) ? NM : (q == 1) ? 200 : int'($urandom_range(1, NM));
      for (int j = 0; j < NM; j++)
        pts[j] = (q % 2 == 0) ? {16'($urandom_range(7)), 16'($urandom_range(7))} : $urandom;
      tp = (q % 2 == 0) ? {16'($urandom_range(7)), 16'($urandom_range(7))} : $urandom;
      model(tp, (n > NM) ? NM : n);
      do_query($sformatf("rand%0d", q), tp, n, (q < 2) ? 50 : 75, 1'b0);
    end

    // T6: reset mid-LOAD after 10 points, with points still in flight
    begin
      bit got_done = 1'b0;
      for (int j = 0; j < 20; j++) pts[j] = $urandom;
      @(negedge clk);
      bus.start = 1'b1; bus.test_pt = 32'h0; bus.num_pts = 8'd20;
      @(negedge clk);
      bus.start = 1'b0;
      for (int j = 0; j < 10; j++) begin
        bus.pt_valid = 1'b1; bus.pt_data = pts[j];
        @(negedge clk);
      end
      bus.pt_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("T6 pt_ready", 64'(bus.pt_ready), 64'd0);
      chk("T6 busy",     64'(bus.busy),     64'd0);
      chk("T6 vld",      64'(bus.nbr_vld),  64'd0);
      chk("T6 dist0",    64'(bus.nbr_dist[DW-1:0]), 64'h1_FFFF_FFFF);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.done || bus.nbr_vld != '0) got_done = 1'b1;
      end
      chk("T6 no done/update", 64'(got_done), 64'd0);
      for (int j = 0; j < 12; j++) pts[j] = $urandom;
      model(32'h0100_0200, 12);
      do_query("T6 after", 32'h0100_0200, 12, 80, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
